mesh_input_unit: RTL and testbench

//  Per-port input unit of the 5-port MESH router: buffers single-flit packets arriving from the upstream link,

---
 rtl/mesh_input_unit.sv | 117 +++++++++++
 tb/tb_mesh_input_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mesh_input_unit.sv
// Per-port input unit of the 5-port mesh router.
// Buffers single-flit packets, XY-routes them and requests the switch.
module mesh_input_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int X_NODES    = 4,
  parameter int Y_NODES    = 4,
  parameter int X_LOC      = 0,
  parameter int Y_LOC      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_val,
  output logic                  o_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_val,
  output logic [0:4]            o_output_req,
  input  logic [0:4]            i_output_grant,
  output logic                  o_grant_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = $clog2(X_NODES);
  localparam int YW = $clog2(Y_NODES);
  localparam int EW = DATA_WIDTH + 5;

  localparam logic [XW-1:0] LX  = XW'(X_LOC);
  localparam logic [YW-1:0] LY  = YW'(Y_LOC);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;
  logic [0:4]    w_route;
  logic [EW-1:0] w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic          w_miss;

  assign w_dx = i_data[DATA_WIDTH-1 -: XW];
  assign w_dy = i_data[DATA_WIDTH-1-XW -: YW];

  // XY route: resolve X first, then Y, else deliver locally.
  always_comb begin
    w_route = 5'b10000;
    if (w_dx > LX)
      w_route = 5'b00100;
    else if (w_dx < LX)
      w_route = 5'b00001;
    else if (w_dy > LY)
      w_route = 5'b01000;
    else if (w_dy < LY)
      w_route = 5'b00010;
  end

  assign o_en       = (r_cnt != FULL);
  assign o_data_val = (r_cnt != '0);
  assign w_head     = r_mem[r_rd];

  // Empty head drives zeros so reset clears outputs without clearing storage.
  always_comb begin
    o_data       = '0;
    o_output_req = '0;
    if (o_data_val) begin
      o_data       = w_head[EW-1:5];
      o_output_req = w_head[4:0];
    end
  end

  assign w_push = i_data_val && o_en;
  assign w_hit  = |(i_output_grant & o_output_req);
  assign w_miss = |(i_output_grant & ~o_output_req);
  assign w_pop  = o_data_val && w_hit;

  assign o_grant_err = r_err;

  // Packet storage with its precomputed route.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= {i_data, w_route};
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Sticky flag for grants on unrequested outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_miss)
      r_err <= 1'b1;
  end

endmodule

// File: tb/tb_mesh_input_unit.sv
// Directed bench for mesh_input_unit at router (1,1).
// Hand-computed routes and data order.
module tb_mesh_input_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_data_val = 1'b0;
  logic        o_en;
  logic [31:0] o_data;
  logic        o_data_val;
  logic [0:4]  o_output_req;
  logic [0:4]  i_output_grant = '0;
  logic        o_grant_err;

  int n_cmp = 0;
  int n_bad = 0;

  mesh_input_unit #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4),
    .X_NODES(4),
    .Y_NODES(4),
    .X_LOC(1),
    .Y_LOC(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_data(i_data),
    .i_data_val(i_data_val),
    .o_en(o_en),
    .o_data(o_data),
    .o_data_val(o_data_val),
    .o_output_req(o_output_req),
    .i_output_grant(i_output_grant),
    .o_grant_err(o_grant_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pkt(input logic [1:0] dx,
                                      input logic [1:0] dy,
                                      input logic [27:0] pl);
    return {dx, dy, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_data_val = 1'b0;
    i_output_grant = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [31:0] tp [5];
  logic [4:0]  tr [5];

  initial begin
    // 1: reset mid-transfer
    #1;
    chk("rst_en", o_en, 1);
    chk("rst_val", o_data_val, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      i_data = pkt(2'd0, 2'd0, 28'(i + 16));
      i_data_val = 1'b1;
      tick();
    end
    i_data_val = 1'b0;
    chk("t1_held", o_data_val, 1);
    chk("t1_req", o_output_req, 5'b00001);
    i_output_grant = 5'b00010;
    tick();
    i_output_grant = '0;
    chk("t1_err", o_grant_err, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_en", o_en, 1);
    chk("t1_val", o_data_val, 0);
    chk("t1_req0", o_output_req, 0);
    chk("t1_data0", o_data, 0);
    chk("t1_err0", o_grant_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("t1_empty", o_data_val, 0);

    // 2: XY routes
    tp[0] = pkt(2'd2, 2'd1, 28'h1); tr[0] = 5'b00100;
    tp[1] = pkt(2'd0, 2'd1, 28'h2); tr[1] = 5'b00001;
    tp[2] = pkt(2'd1, 2'd2, 28'h3); tr[2] = 5'b01000;
    tp[3] = pkt(2'd1, 2'd0, 28'h4); tr[3] = 5'b00010;
    tp[4] = pkt(2'd1, 2'd1, 28'h5); tr[4] = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      i_data = tp[i];
      i_data_val = 1'b1;
      tick();
      i_data_val = 1'b0;
      chk($sformatf("t2_req%0d", i), o_output_req, tr[i]);
      chk($sformatf("t2_dat%0d", i), o_data, tp[i]);
      i_output_grant = tr[i];
      tick();
      i_output_grant = '0;
    end
    chk("t2_empty", o_data_val, 0);
    chk("t2_noerr", o_grant_err, 0);

    // 3: fill, overflow ignored, pop reopens
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_en%0d", i), o_en, 1);
      i_data = pkt(2'd0, 2'd0, 28'(i + 32));
      i_data_val = 1'b1;
      tick();
    end
    chk("t3_full", o_en, 0);
    i_data = pkt(2'd3, 2'd3, 28'hBAD);
    tick();
    chk("t3_stillfull", o_en, 0);
    i_output_grant = 5'b00001;
    tick();
    i_output_grant = '0;
    i_data_val = 1'b0;
    chk("t3_reopen", o_en, 1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t3_dat%0d", i), o_data, pkt(2'd0, 2'd0, 28'(i + 32)));
      i_output_grant = 5'b00001;
      tick();
      i_output_grant = '0;
    end
    chk("t3_drained", o_data_val, 0);

    // 4: steady push+pop, pointers wrap
    do_reset();
    for (int i = 0; i < 2; i++) begin
      i_data = pkt(2'd2, 2'd1, 28'(i + 64));
      i_data_val = 1'b1;
      tick();
    end
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("t4_dat%0d", j), o_data, pkt(2'd2, 2'd1, 28'(j + 64)));
      chk($sformatf("t4_en%0d", j), o_en, 1);
      i_data = pkt(2'd2, 2'd1, 28'(j + 66));
      i_data_val = 1'b1;
      i_output_grant = 5'b00100;
      tick();
    end
    i_data_val = 1'b0;
    for (int j = 10; j < 12; j++) begin
      chk($sformatf("t4_tail%0d", j), o_data, pkt(2'd2, 2'd1, 28'(j + 64)));
      tick();
    end
    i_output_grant = '0;
    chk("t4_count2", o_data_val, 0);

    // 5: wrong grant
    do_reset();
    i_data = pkt(2'd2, 2'd1, 28'h55);
    i_data_val = 1'b1;
    tick();
    i_data_val = 1'b0;
    chk("t5_req", o_output_req, 5'b00100);
    chk("t5_err0", o_grant_err, 0);
    i_output_grant = 5'b01000;
    tick();
    i_output_grant = '0;
    chk("t5_err1", o_grant_err, 1);
    chk("t5_keep", o_data, pkt(2'd2, 2'd1, 28'h55));
    chk("t5_val", o_data_val, 1);
    tick();
    chk("t5_sticky", o_grant_err, 1);

    // 6: push and grant into empty FIFO
    do_reset();
    i_data = pkt(2'd1, 2'd1, 28'h66);
    i_data_val = 1'b1;
    i_output_grant = 5'b10000;
    tick();
    i_data_val = 1'b0;
    i_output_grant = '0;
    chk("t6_val", o_data_val, 1);
    chk("t6_req", o_output_req, 5'b10000);
    chk("t6_dat", o_data, pkt(2'd1, 2'd1, 28'h66));
    chk("t6_err", o_grant_err, 1);
    i_output_grant = 5'b10000;
    tick();
    i_output_grant = '0;
    chk("t6_pop", o_data_val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
